// File: rtl/snake_frame_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snake_frame_sequencer_if                                                   |
// | Tick, snake stream, coin, screen write port and status bundle for the      |
// | frame sequencer.                                                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface snake_frame_sequencer_if #(
    parameter int H = 32,
    parameter int V = 32
);
    localparam int XB = $clog2(H);
    localparam int YB = $clog2(V);
    localparam int AB = $clog2(H * V);

    logic          game_tick;
    logic          snake_valid;
    logic [XB-1:0] snake_x;
    logic [YB-1:0] snake_y;
    logic          snake_end;
    logic          coin_exists;
    logic [XB-1:0] coin_x;
    logic [YB-1:0] coin_y;
    logic          snake_shift;
    logic          mem_we;
    logic [AB-1:0] mem_addr;
    logic [1:0]    mem_data;
    logic          busy;
    logic          frame_done;
    logic          tick_overrun;
    logic          snake_fault;

    // master is the sequencer itself; slave is the surrounding game logic
    modport master (
        input  game_tick, snake_valid, snake_x, snake_y, snake_end,
        input  coin_exists, coin_x, coin_y,
        output snake_shift, mem_we, mem_addr, mem_data,
        output busy, frame_done, tick_overrun, snake_fault
    );

    modport slave (
        output game_tick, snake_valid, snake_x, snake_y, snake_end,
        output coin_exists, coin_x, coin_y,
        input  snake_shift, mem_we, mem_addr, mem_data,
        input  busy, frame_done, tick_overrun, snake_fault
    );
endinterface
`default_nettype wire

// File: rtl/snake_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snake_frame_sequencer                                                      |
// | Redraws the screen memory once per game tick: clear, snake body, coin.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module snake_frame_sequencer #(
    parameter int         H             = 32,
    parameter int         V             = 32,
    parameter logic [1:0] BG_INDEX      = 2'd0,
    parameter logic [1:0] SNAKE_INDEX   = 2'd1,
    parameter logic [1:0] COIN_INDEX    = 2'd2,
    parameter int         SNAKE_TIMEOUT = 2048
) (
    input  logic                          clk,
    input  logic                          rst_n,
    snake_frame_sequencer_if.master       bus
);
    localparam int AB = $clog2(H * V);
    localparam int TW = (SNAKE_TIMEOUT > 1) ? $clog2(SNAKE_TIMEOUT) : 1;

    localparam logic [AB-1:0] LAST_ADDR   = AB'(H * V - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(SNAKE_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_SNAKE = 3'd3;
    localparam logic [2:0] S_COIN  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [AB-1:0] clr_cnt_q, clr_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          pending_q, pending_d;
    logic          snake_shift_q, snake_shift_d;
    logic          mem_we_q, mem_we_d;
    logic [AB-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]    mem_data_q, mem_data_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          tick_overrun_q, tick_overrun_d;
    logic          snake_fault_q, snake_fault_d;

    logic [AB-1:0] snake_addr;
    logic [AB-1:0] coin_addr;

    // Row-major cell address; out-of-range coordinates simply wrap at AB bits
    assign snake_addr = AB'(bus.snake_y) * AB'(H) + AB'(bus.snake_x);
    assign coin_addr  = AB'(bus.coin_y)  * AB'(H) + AB'(bus.coin_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            clr_cnt_q      <= '0;
            to_cnt_q       <= '0;
            pending_q      <= 1'b0;
            snake_shift_q  <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            tick_overrun_q <= 1'b0;
            snake_fault_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            to_cnt_q       <= to_cnt_d;
            pending_q      <= pending_d;
            snake_shift_q  <= snake_shift_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
            tick_overrun_q <= tick_overrun_d;
            snake_fault_q  <= snake_fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.game_tick || pending_q) state_d = S_CLEAR;
            S_CLEAR: if (clr_cnt_q == LAST_ADDR) state_d = S_SHIFT;
            S_SHIFT: state_d = S_SNAKE;
            S_SNAKE: if (bus.snake_end || (to_cnt_q == TIMEOUT_MAX)) state_d = S_COIN;
            S_COIN:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        clr_cnt_d      = clr_cnt_q;
        to_cnt_d       = to_cnt_q;
        pending_d      = pending_q;
        tick_overrun_d = tick_overrun_q;
        snake_fault_d  = snake_fault_q;
        snake_shift_d  = 1'b0;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_data_d     = mem_data_q;
        frame_done_d   = 1'b0;
        busy_d         = (state_d != S_IDLE);

        // A tick landing on the cycle a queued frame launches stays queued
        if (state_q == S_IDLE) begin
            pending_d = bus.game_tick && pending_q;
        end else if (bus.game_tick) begin
            pending_d = 1'b1;
            if (pending_q) tick_overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                clr_cnt_d = '0;
            end
            S_CLEAR: begin
                mem_we_d   = 1'b1;
                mem_addr_d = clr_cnt_q;
                mem_data_d = BG_INDEX;
                clr_cnt_d  = clr_cnt_q + AB'(1);
            end
            S_SHIFT: begin
                snake_shift_d = 1'b1;
                to_cnt_d      = '0;
            end
            S_SNAKE: begin
                mem_we_d   = bus.snake_valid;
                mem_addr_d = snake_addr;
                mem_data_d = SNAKE_INDEX;
                to_cnt_d   = to_cnt_q + TW'(1);
                if (!bus.snake_end && (to_cnt_q == TIMEOUT_MAX)) snake_fault_d = 1'b1;
            end
            S_COIN: begin
                mem_we_d   = bus.coin_exists;
                mem_addr_d = coin_addr;
                mem_data_d = COIN_INDEX;
            end
            S_DONE: begin
                frame_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.snake_shift  = snake_shift_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data     = mem_data_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.tick_overrun = tick_overrun_q;
    assign bus.snake_fault  = snake_fault_q;

endmodule
`default_nettype wire
